// File: rtl/score_plotter.sv
// score_plotter: draws a two-digit decimal score (0..99) into a framebuffer
// from a sprite ROM. The tens digit goes in slot 0 and the ones digit sits
// DIGIT_W pixels to its right. Each slot is scanned row by row, with
// columns ascending inside each row.
//
// Ports
//   clock, reset      sole clock (rising edge); async active-low reset
//   start             draw request, only sampled while idle
//   score             value to draw (values above 99 are shown as 99)
//   base_x, base_y    screen position of the sprite's top-left pixel
//   rom_digit/i/j     sprite ROM address (digit, column, row)
//   rom_colour        ROM pixel data, arriving one cycle after its address
//   vga_x/y/colour    framebuffer write position and colour
//   plot              framebuffer write enable, one pixel per high cycle
//   busy              high while a draw is in progress
//   done              one-cycle pulse after the final pixel
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; inputs are latched when start is seen
// DRAW  | one ROM address per cycle; the previous pixel is plotted
// FLUSH | last pixel plotted, no new address issued
// DONE  | done pulse, then back to IDLE

module score_plotter #(
    parameter int DIGIT_W            = 16,
    parameter int DIGIT_H            = 32,
    parameter int BLANK_LEADING_ZERO = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] score,
    input  logic [7:0] base_x,
    input  logic [6:0] base_y,
    output logic [3:0] rom_digit,
    output logic [3:0] rom_i,
    output logic [4:0] rom_j,
    input  logic [2:0] rom_colour,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, DRAW, FLUSH, DONE} state_t;

    state_t     state_q;
    logic [3:0] tens_q, ones_q;
    logic [7:0] base_x_q;
    logic [6:0] base_y_q;
    logic [3:0] i_q;
    logic [4:0] j_q;
    logic       d_q;
    logic [3:0] rom_digit_q;
    logic [7:0] vga_x_q;
    logic [6:0] vga_y_q;
    logic       blank_q;
    logic       plot_q, busy_q, done_q;

    logic [6:0] score_sat;
    logic [3:0] tens_d, ones_d;
    logic       last_col, last_row, last_addr;
    logic [3:0] i_d;
    logic [4:0] j_d;
    logic       d_d;
    logic [7:0] x_off;
    logic [7:0] vga_x_d;
    logic [6:0] vga_y_d;
    logic       blank_d;

    // Digits are split from the incoming value so the first ROM address
    // (tens digit) can be issued on the same edge that latches the score.
    always_comb begin
        score_sat = (score > 7'd99) ? 7'd99 : score;
        tens_d    = 4'(score_sat / 7'd10);
        ones_d    = 4'(score_sat % 7'd10);
    end

    always_comb begin
        last_col  = (i_q == 4'(DIGIT_W - 1));
        last_row  = (j_q == 5'(DIGIT_H - 1));
        last_addr = d_q && last_col && last_row;
        i_d       = last_col ? 4'd0 : i_q + 4'd1;
        j_d       = last_col ? (last_row ? 5'd0 : j_q + 5'd1) : j_q;
        d_d       = (last_col && last_row) ? 1'b1 : d_q;
        x_off     = d_q ? 8'(DIGIT_W) : 8'd0;
        // 8-bit and 7-bit sums wrap naturally at the screen edges.
        vga_x_d   = base_x_q + x_off + {4'd0, i_q};
        vga_y_d   = base_y_q + {2'd0, j_q};
        blank_d   = (BLANK_LEADING_ZERO != 0) && !d_q && (tens_q == 4'd0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            tens_q      <= 4'd0;
            ones_q      <= 4'd0;
            base_x_q    <= 8'd0;
            base_y_q    <= 7'd0;
            i_q         <= 4'd0;
            j_q         <= 5'd0;
            d_q         <= 1'b0;
            rom_digit_q <= 4'd0;
            vga_x_q     <= 8'd0;
            vga_y_q     <= 7'd0;
            blank_q     <= 1'b0;
            plot_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    plot_q <= 1'b0;
                    done_q <= 1'b0;
                    if (start) begin
                        tens_q      <= tens_d;
                        ones_q      <= ones_d;
                        base_x_q    <= base_x;
                        base_y_q    <= base_y;
                        i_q         <= 4'd0;
                        j_q         <= 5'd0;
                        d_q         <= 1'b0;
                        rom_digit_q <= tens_d;
                        busy_q      <= 1'b1;
                        state_q     <= DRAW;
                    end
                end
                DRAW: begin
                    // Position travels one stage behind the address so it
                    // lines up with rom_colour from the synchronous ROM.
                    plot_q  <= 1'b1;
                    vga_x_q <= vga_x_d;
                    vga_y_q <= vga_y_d;
                    blank_q <= blank_d;
                    if (last_addr) begin
                        state_q <= FLUSH;
                    end else begin
                        i_q         <= i_d;
                        j_q         <= j_d;
                        d_q         <= d_d;
                        rom_digit_q <= d_d ? ones_q : tens_q;
                    end
                end
                FLUSH: begin
                    plot_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    plot_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rom_digit  = rom_digit_q;
    assign rom_i      = i_q;
    assign rom_j      = j_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    // ROM data is only passed through on plot cycles, so it reads as 0 at
    // all other times, including while reset is held.
    assign vga_colour = (plot_q && !blank_q) ? rom_colour : 3'd0;
    assign plot       = plot_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: doc/score_plotter.md
SCORE_PLOTTER -- requirements
Module: score_plotter

Interface
REQ-001 Parameter: DIGIT_W, 16, sprite width in pixels per digit.
REQ-002 Parameter: DIGIT_H, 32, sprite height in rows per digit.
REQ-003 Parameter: BLANK_LEADING_ZERO, 1, when 1 a tens digit of 0 is drawn as colour 3'b000.
REQ-004 The block SHALL have exactly these ports:
- clock  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request to draw the score, sampled in IDLE.
- score  in  7  value to draw, 0..99.
- base_x  in  8  screen x of the sprite's top-left pixel.
- base_y  in  7  screen y of the sprite's top-left pixel.
- rom_digit  out  4  digit index 0..9 sent to the sprite ROM.
- rom_i  out  4  sprite column sent to the ROM.
- rom_j  out  5  sprite row sent to the ROM.
- rom_colour  in  3  ROM pixel colour, valid one cycle after the address.
- vga_x  out  8  framebuffer write x.
- vga_y  out  7  framebuffer write y.
- vga_colour  out  3  framebuffer write colour.
- plot  out  1  framebuffer write enable, one pixel per high cycle.
- busy  out  1  high while a draw is in progress.
- done  out  1  one-cycle pulse after the final pixel.

Function
REQ-005 The FSM SHALL have the states IDLE, DRAW, FLUSH and DONE.
REQ-006 In IDLE with start=1 at edge k, the block SHALL latch score, base_x and base_y and enter DRAW; busy SHALL be high from cycle k+1.
REQ-007 Latched score values above 99 SHALL saturate to 99; tens = score/10 and ones = score%10 SHALL be computed from the latched value.
REQ-008 DRAW SHALL issue one address per cycle, n = 0..2*DIGIT_W*DIGIT_H-1 (1023 by default), with n presented in cycle k+1+n.
REQ-009 Scan order SHALL be digit 0 (tens) then digit 1 (ones), rows j ascending, and columns i ascending within each row.
REQ-010 Address n SHALL drive rom_digit with the current digit value, rom_i = i and rom_j = j.
REQ-011 The result for address n SHALL appear in cycle k+2+n with plot=1 and vga_colour=rom_colour.
REQ-012 In that cycle vga_x SHALL equal (base_x + d*DIGIT_W + i) mod 256 and vga_y SHALL equal (base_y + j) mod 128, where d is the digit slot.
REQ-013 If BLANK_LEADING_ZERO=1 and tens=0, vga_colour SHALL be 3'b000 for every digit-0 pixel, and those pixels SHALL still be plotted.
REQ-014 After issuing the last address the FSM SHALL enter FLUSH for one cycle (k+1025), in which the last plot occurs and no new address is issued.
REQ-015 DONE SHALL last exactly one cycle (k+1026) with done=1, busy=0 and plot=0; the FSM SHALL then return to IDLE.
REQ-016 start SHALL be ignored in DRAW, FLUSH and DONE; latched inputs SHALL NOT change during a draw.
REQ-017 plot SHALL be high for exactly 1024 consecutive cycles per draw and low at all other times.
REQ-018 rom_* outputs MAY hold any value when not in DRAW, and rom_colour SHALL be ignored outside the plot pipeline.

Reset
REQ-019 reset=0 SHALL immediately force the FSM to IDLE and clear all counters and every output (plot, busy, done, vga_*, rom_*) to 0, regardless of the clock.
REQ-020 A reset asserted mid-draw SHALL abort the draw, produce no further plot cycles and no done pulse, and require a new start after release.
REQ-021 The first start SHALL be accepted on the first rising edge after reset returns high.

Verification
REQ-022 Scenario: reset release, score=42, base=(10,20), start for one cycle, ROM model colour = digit -> plot high cycles k+2..k+1025; first pixel (10,20) colour 4; pixel n=512 at (26,20) colour 2; last pixel (41,51); done at k+1026 only.
REQ-023 Scenario: score=7 with BLANK_LEADING_ZERO=1 -> all 512 tens pixels have colour 0; ones pixels have ROM colour with rom_digit=7.
REQ-024 Scenario: score=120 -> draws 99 (rom_digit 9 for both slots).
REQ-025 Scenario: base_x=250, base_y=120 -> vga_x wraps (pixel i=6 of digit 0 gives x=0) and vga_y wraps (j=8 gives y=0).
REQ-026 Scenario: start pulsed again at k+100 and score changed mid-draw -> no restart, exactly 1024 plots, drawn values unchanged.
REQ-027 Scenario: reset=0 at k+300 between clock edges -> plot, busy and done drop to 0 at once; no done pulse follows; a new start after release gives a full, correct draw.
